// File: rtl/keypad_matrix_emu.sv
`default_nettype none
// =============================================================================
// keypad_matrix_emu : row-side 4x4 keypad responder with contact-bounce model
// Revision 1.0
// =============================================================================
module keypad_matrix_emu #(
   parameter int unsigned TICK_DIV     = 50000,
   parameter int unsigned BOUNCE_TICKS = 4,
   parameter int unsigned GAP_TICKS    = 20,
   parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_key,
   input  logic [15:0] cmd_hold,
   input  logic [3:0]  c_pin,
   output logic [3:0]  r_pin,
   output logic        busy,
   output logic        done
);

   localparam int unsigned  CW         = $clog2(TICK_DIV);
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
   localparam logic [16:0]  BOUNCE_LIM = 17'(BOUNCE_TICKS);
   localparam logic [16:0]  GAP_LIM    = 17'(GAP_TICKS);
   localparam bit           HAS_BOUNCE = (BOUNCE_TICKS != 0);

   typedef enum logic [2:0] {
      S_IDLE         = 3'd0,
      S_PRESS_BOUNCE = 3'd1,
      S_HOLD         = 3'd2,
      S_REL_BOUNCE   = 3'd3,
      S_GAP          = 3'd4
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] tick_cnt;
   logic          tick;
   logic [7:0]    lfsr;
   logic [7:0]    lfsr_step;
   logic [7:0]    lfsr_upd;
   logic [15:0]   phase;
   logic [16:0]   phase_limit;
   logic          phase_end;
   logic [3:0]    key_l;
   logic [15:0]   hold_l;
   logic          contact;
   logic          contact_nxt;
   logic          done_nxt;
   logic          accept;
   logic [3:0]    r_nxt;

   assign cmd_ready = (state == S_IDLE) && !done && !rst;
   assign busy      = (state != S_IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign tick      = (tick_cnt == TICK_LAST);

   // Fibonacci LFSR, taps 8,6,5,4; lfsr_upd is the value the register holds after this edge
   assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign lfsr_upd  = tick ? lfsr_step : lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (accept || tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= LFSR_SEED;
      end else if (tick) begin
         lfsr <= lfsr_step;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_l  <= '0;
         hold_l <= 16'd1;
      end else if (accept) begin
         key_l  <= cmd_key;
         hold_l <= (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         phase   <= '0;
         contact <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         contact <= contact_nxt;
         done    <= done_nxt;
         if (state_nxt != state) begin
            phase <= '0;
         end else if (tick) begin
            phase <= phase + 16'd1;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      contact_nxt = contact;
      done_nxt    = 1'b0;
      phase_limit = 17'd1;

      unique case (state)
         S_PRESS_BOUNCE, S_REL_BOUNCE: phase_limit = BOUNCE_LIM;
         S_HOLD:                       phase_limit = {1'b0, hold_l};
         S_GAP:                        phase_limit = GAP_LIM;
         default:                      phase_limit = 17'd1;
      endcase

      phase_end = tick && (({1'b0, phase} + 17'd1) >= phase_limit);

      unique case (state)
         S_IDLE: begin
            contact_nxt = 1'b0;
            if (accept) begin
               if (HAS_BOUNCE) begin
                  state_nxt   = S_PRESS_BOUNCE;
                  contact_nxt = lfsr_upd[0];
               end else begin
                  state_nxt   = S_HOLD;
                  contact_nxt = 1'b1;
               end
            end
         end
         S_PRESS_BOUNCE: begin
            if (phase_end) begin
               state_nxt   = S_HOLD;
               contact_nxt = 1'b1;
            end else if (tick) begin
               contact_nxt = lfsr_upd[0];
            end
         end
         S_HOLD: begin
            contact_nxt = 1'b1;
            if (phase_end) begin
               if (HAS_BOUNCE) begin
                  state_nxt   = S_REL_BOUNCE;
                  contact_nxt = lfsr_upd[0];
               end else begin
                  state_nxt   = S_GAP;
                  contact_nxt = 1'b0;
               end
            end
         end
         S_REL_BOUNCE: begin
            if (phase_end) begin
               state_nxt   = S_GAP;
               contact_nxt = 1'b0;
            end else if (tick) begin
               contact_nxt = lfsr_upd[0];
            end
         end
         S_GAP: begin
            contact_nxt = 1'b0;
            if (phase_end) begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt   = S_IDLE;
            contact_nxt = 1'b0;
         end
      endcase
   end

   // Matrix behaviour: our row closes whenever our own column is driven
   always_comb begin
      r_nxt = 4'b0000;
      if (contact && c_pin[key_l[3:2]]) begin
         r_nxt[key_l[1:0]] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pin <= 4'b0000;
      end else begin
         r_pin <= r_nxt;
      end
   end

endmodule
`default_nettype wire
